alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n presents an operation.
- req0_ready / req1_ready  out  1  arbiter accepts requester n this cycle.
- req0_a / req1_a  in  4  operand A.
- req0_b / req1_b  in  4  operand B.
- req0_sel / req1_sel  in  3  ALU op code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 shl1, 111 shr1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  4  operation result, modulo 16.
- rsp_zero  out  1  1 when rsp_result == 0.
- rsp_id  out  1  requester that issued the operation.
- busy  out  1  1 whenever state != IDLE.
- ops_done  out  8  count of completed responses.
REQ-002 SHALL have no parameters: all widths are fixed as listed.

Function
REQ-003 SHALL instantiate exactly one shared 4-bit ALU datapath implementing the op codes in REQ-001.
REQ-004 SHALL use the FSM states IDLE, EXEC and RESP.
REQ-005 IDLE: grant = arbitration over the valid requests; reqN_ready = (state==IDLE) && grant==N; both readys are 0 outside IDLE.
REQ-006 Acceptance: on reqN_valid && reqN_ready, the block registers a, b, sel and id=N, then goes to EXEC.
REQ-007 EXEC: the ALU evaluates the registered operands; the block registers result and zero, then goes to RESP (one cycle).
REQ-008 RESP: rsp_valid=1; rsp_result, rsp_zero and rsp_id are held stable until rsp_valid && rsp_ready.
REQ-009 On the RESP handshake the block increments ops_done and goes to IDLE.
REQ-010 Latency: acceptance in cycle N gives rsp_valid in cycle N+2 at the earliest.
REQ-011 Throughput is at most one operation per 3 cycles, and a new grant is possible in the cycle after the response handshake.
REQ-012 ops_done SHALL wrap from 255 to 0.
REQ-013 Sub and shift results SHALL truncate to 4 bits (0-1 = 4'hF; 4'h8<<1 = 4'h0, giving zero=1).
REQ-014 When only one valid request is present, that requester is granted.
REQ-015 When no request is valid, the block stays in IDLE with both readys 0.
REQ-016 rsp_valid SHALL NOT depend combinationally on rsp_ready.
REQ-017 reqN_ready MAY depend combinationally on req valids.
REQ-018 Requester inputs are ignored outside the acceptance cycle.

Reset
REQ-019 rst SHALL be sampled on the rising clk edge and take priority over all other behaviour.
REQ-020 Reset values: state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, busy=0, ops_done=0, last_grant=1.
REQ-021 Reset during EXEC or RESP discards the in-flight operation without producing a response and without incrementing ops_done.

Configuration
REQ-022 Macro ALU_ARBITER_ROUND_ROBIN_EN selects the arbitration policy.
- Defined: on simultaneous valids, the block grants the requester other than last_grant; last_grant updates on each acceptance.
- Undefined: fixed priority, requester 0 always wins ties; last_grant logic is absent.

Verification
REQ-023 Single request: reset; req0 a=3 b=5 sel=000, rsp_ready=1 -> req0_ready cycle N, rsp_valid cycle N+2, result=8, zero=0, id=0, ops_done=1.
REQ-024 Wrap and zero: req1 a=0 b=1 sel=001 -> result=F, zero=0, id=1; then a=8 sel=110 -> result=0, zero=1.
REQ-025 Tie (ROUND_ROBIN_EN defined): both valid continuously for 4 operations -> ids 0,1,0,1; with the macro undefined -> ids 0,0,0,0.
REQ-026 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, both readys 0, ops_done unchanged; then rsp_ready=1 -> IDLE next cycle.
REQ-027 Reset mid-operation: rst in EXEC -> next cycle state IDLE, rsp_valid=0, ops_done unchanged.
REQ-028 Counter wrap: 256 completed operations -> ops_done=0, busy=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared 4-bit ALU, with an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins ties.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_id,
  output logic       busy,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, b_q;
  logic [2:0] sel_q;
  logic       id_q;
  logic [3:0] result_q;
  logic       zero_q;
  logic [7:0] ops_done_q;
  logic       grant;
  logic       any_valid;
  logic       accept;
  logic       rsp_hs;
  logic [3:0] alu_y;

  function automatic logic [3:0] alu_op(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel);
    logic [3:0] y;
    case (sel)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      3'b101:  y = ~(a | b);
      3'b110:  y = {a[2:0], 1'b0};
      default: y = {1'b0, a[3:1]};
    endcase
    return y;
  endfunction

  assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q;

  // On a tie, hand the grant to whoever did not win last time.
  assign grant = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;

  always_ff @(posedge clk) begin
    if (rst)         last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= grant;
  end
`else
  assign grant = ~req0_valid;
`endif

  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs = rsp_valid && rsp_ready;
  assign alu_y  = alu_op(a_q, b_q, sel_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = any_valid && !grant;
        req1_ready = any_valid && grant;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture: pure datapath, only loaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= grant ? req1_a   : req0_a;
      b_q   <= grant ? req1_b   : req0_b;
      sel_q <= grant ? req1_sel : req0_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= 1'b0;
      result_q   <= 4'h0;
      zero_q     <= 1'b0;
      ops_done_q <= 8'h00;
    end else begin
      if (accept) id_q <= grant;
      if (state_q == EXEC) begin
        result_q <= alu_y;
        zero_q   <= (alu_y == 4'h0);
      end
      if (rsp_hs) ops_done_q <= ops_done_q + 8'h01;
    end
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = id_q;
  assign ops_done   = ops_done_q;

endmodule
